// File: rtl/priority_rr_arbiter.sv
// Zero-latency priority arbiter with round-robin tie-break and packet locking.
// Optional starvation aging is enabled by defining PRIORITY_RR_ARB_AGING_EN.
module priority_rr_arbiter #(
    parameter int INPUT_NUM        = 4,
    parameter int INPUT_NUM_IDX_W  = (INPUT_NUM > 1) ? $clog2(INPUT_NUM) : 1,
    parameter int INPUT_PRIORITY_W = 4,
    parameter int AGE_THRESHOLD    = 15
) (
    input  logic                                              clk,
    input  logic                                              rst,
    input  logic [INPUT_NUM-1:0]                              req_vld_i,
    input  logic [INPUT_NUM-1:0][INPUT_PRIORITY_W-1:0]        req_priority_i,
    input  logic [INPUT_NUM-1:0]                              req_tail_i,
    input  logic                                              gnt_rdy_i,
    output logic                                              gnt_vld_o,
    output logic [INPUT_NUM-1:0]                              gnt_oh_o,
    output logic [INPUT_NUM_IDX_W-1:0]                        gnt_idx_o,
    output logic                                              locked_o
);

    localparam int SUM_W = INPUT_NUM_IDX_W + 1;

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                       state_q, state_d;
    logic [INPUT_NUM_IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [INPUT_NUM_IDX_W-1:0]   lock_idx_q, lock_idx_d;

    logic [INPUT_PRIORITY_W-1:0]  max_pri;
    logic [INPUT_NUM-1:0]         top_cand;
    logic [INPUT_NUM-1:0]         cand;
    logic [2*INPUT_NUM-1:0]       cand_rot;
    logic                         rr_found;
    logic [SUM_W-1:0]             rr_sum;
    logic [INPUT_NUM_IDX_W-1:0]   rr_idx;
    logic [INPUT_NUM-1:0]         lock_oh;

    logic                         gnt_vld;
    logic [INPUT_NUM_IDX_W-1:0]   gnt_idx;
    logic [INPUT_NUM-1:0]         gnt_oh;
    logic                         xfer;
    logic                         xfer_tail;
    logic [INPUT_NUM_IDX_W-1:0]   rr_next;

    // Highest priority among the valid requesters.
    always_comb begin
        max_pri = '0;
        for (int i = 0; i < INPUT_NUM; i++) begin
            if (req_vld_i[i] && (req_priority_i[i] > max_pri)) begin
                max_pri = req_priority_i[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            top_cand[i] = req_vld_i[i] && (req_priority_i[i] == max_pri);
        end
    end

`ifdef PRIORITY_RR_ARB_AGING_EN
    localparam int AGE_W = (AGE_THRESHOLD > 1) ? $clog2(AGE_THRESHOLD + 1) : 1;

    logic [AGE_W-1:0]     age_q [INPUT_NUM];
    logic [INPUT_NUM-1:0] aged;

    // NOTE: a small per-requester register array is reset like any other flop;
    // only true RAM macros are left without reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                age_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < INPUT_NUM; i++) begin
                if (xfer && gnt_oh[i]) begin
                    age_q[i] <= '0;
                end else if (req_vld_i[i] && (state_q == ST_IDLE) &&
                             (age_q[i] < AGE_W'(AGE_THRESHOLD))) begin
                    age_q[i] <= age_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            aged[i] = req_vld_i[i] && (age_q[i] >= AGE_W'(AGE_THRESHOLD));
        end
    end

    // Starved requesters override priority entirely.
    assign cand = (|aged) ? aged : top_cand;
`else
    assign cand = top_cand;
`endif

    // Round-robin pick: rotate so rr_ptr sits at bit 0, take the first set bit.
    always_comb begin
        cand_rot = {cand, cand} >> rr_ptr_q;
        rr_found = 1'b0;
        rr_sum   = {1'b0, rr_ptr_q};
        for (int k = 0; k < INPUT_NUM; k++) begin
            if (!rr_found && cand_rot[k]) begin
                rr_found = 1'b1;
                rr_sum   = {1'b0, rr_ptr_q} + SUM_W'(k);
            end
        end
        if (rr_sum >= SUM_W'(INPUT_NUM)) begin
            rr_sum = rr_sum - SUM_W'(INPUT_NUM);
        end
        rr_idx = rr_sum[INPUT_NUM_IDX_W-1:0];
    end

    always_comb begin
        for (int i = 0; i < INPUT_NUM; i++) begin
            lock_oh[i] = (lock_idx_q == INPUT_NUM_IDX_W'(i));
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a variable unassigned and infer a latch.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        if (!rst) begin
            if (state_q == ST_LOCKED) begin
                gnt_vld = |(req_vld_i & lock_oh);
                gnt_idx = gnt_vld ? lock_idx_q : '0;
            end else begin
                gnt_vld = rr_found;
                gnt_idx = rr_found ? rr_idx : '0;
            end
        end
        for (int i = 0; i < INPUT_NUM; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == INPUT_NUM_IDX_W'(i));
        end
    end

    assign xfer      = gnt_vld & gnt_rdy_i;
    assign xfer_tail = xfer & (|(req_tail_i & gnt_oh));
    assign rr_next   = (gnt_idx == INPUT_NUM_IDX_W'(INPUT_NUM - 1)) ? '0 : gnt_idx + 1'b1;

    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        rr_ptr_d   = rr_ptr_q;
        if (xfer) begin
            if (xfer_tail) begin
                state_d  = ST_IDLE;
                rr_ptr_d = rr_next;
            end else begin
                state_d    = ST_LOCKED;
                lock_idx_d = gnt_idx;
            end
        end
    end

    // NOTE: state is written only with non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rr_ptr_q   <= '0;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    assign gnt_vld_o = gnt_vld;
    assign gnt_idx_o = gnt_idx;
    assign gnt_oh_o  = gnt_oh;
    assign locked_o  = !rst && (state_q == ST_LOCKED);

endmodule

// File: tb/tb_priority_rr_arbiter.sv
// Self-checking bench for priority_rr_arbiter: a behavioural model pushes the
// expected grant per cycle into a queue, which is popped and compared mid-cycle.
module tb_priority_rr_arbiter;

    localparam int N      = 4;
    localparam int AGE_TH = 15;

    logic                clk = 1'b0;
    logic                rst;
    logic [N-1:0]        vld;
    logic [N-1:0][3:0]   pri;
    logic [N-1:0]        tail;
    logic                rdy;
    logic                gnt_vld;
    logic [N-1:0]        gnt_oh;
    logic [1:0]          gnt_idx;
    logic                locked;

    // Single-requester instance
    logic                v1, t1, r1;
    logic [0:0][3:0]     p1;
    logic                gnt_vld1;
    logic [0:0]          gnt_oh1;
    logic [0:0]          gnt_idx1;
    logic                locked1;

    always #5 clk = ~clk;

    priority_rr_arbiter #(.INPUT_NUM(N), .AGE_THRESHOLD(AGE_TH)) dut (
        .clk(clk), .rst(rst), .req_vld_i(vld), .req_priority_i(pri),
        .req_tail_i(tail), .gnt_rdy_i(rdy), .gnt_vld_o(gnt_vld),
        .gnt_oh_o(gnt_oh), .gnt_idx_o(gnt_idx), .locked_o(locked)
    );

    priority_rr_arbiter #(.INPUT_NUM(1)) dut1 (
        .clk(clk), .rst(rst), .req_vld_i(v1), .req_priority_i(p1),
        .req_tail_i(t1), .gnt_rdy_i(r1), .gnt_vld_o(gnt_vld1),
        .gnt_oh_o(gnt_oh1), .gnt_idx_o(gnt_idx1), .locked_o(locked1)
    );

    typedef struct {
        bit          vld;
        int          idx;
        bit [N-1:0]  oh;
        bit          locked;
        string       tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    bit   m_locked;
    int   m_lock;
    int   m_rr;
    int   m_age [N];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_locked = 1'b0;
        m_lock   = 0;
        m_rr     = 0;
        for (int j = 0; j < N; j++) m_age[j] = 0;
    endtask

    // Expected grant from the model's current state and the driven inputs.
    function automatic void model_expect(output bit v, output int idx);
        bit [N-1:0] c;
        bit [N-1:0] aged;
        bit         top;
        int         j;
        v   = 1'b0;
        idx = 0;
        if (m_locked) begin
            v   = vld[m_lock];
            idx = v ? m_lock : 0;
            return;
        end
        c = '0;
        for (int a = 0; a < N; a++) begin
            if (vld[a]) begin
                top = 1'b1;
                for (int b = 0; b < N; b++)
                    if (vld[b] && (pri[b] > pri[a])) top = 1'b0;
                c[a] = top;
            end
        end
`ifdef PRIORITY_RR_ARB_AGING_EN
        aged = '0;
        for (int a = 0; a < N; a++) aged[a] = vld[a] && (m_age[a] >= AGE_TH);
        if (|aged) c = aged;
`else
        aged = '0;
`endif
        for (int off = 0; off < N; off++) begin
            j = (m_rr + off) % N;
            if (!v && c[j]) begin
                v   = 1'b1;
                idx = j;
            end
        end
    endfunction

    // One cycle: inputs are already driven (we are just after a rising edge).
    task automatic step(input string tag, input int want);
        exp_t e;
        exp_t g;
        bit   v;
        int   idx;
        bit   xf;
        model_expect(v, idx);
        e.vld    = v;
        e.idx    = idx;
        e.oh     = v ? (N'(1) << idx) : '0;
        e.locked = m_locked;
        e.tag    = tag;
        sb.push_back(e);
        @(negedge clk);
        g = sb.pop_front();
        check({g.tag, "_vld"},    32'(gnt_vld), 32'(g.vld));
        check({g.tag, "_idx"},    32'(gnt_idx), g.idx);
        check({g.tag, "_oh"},     32'(gnt_oh),  32'(g.oh));
        check({g.tag, "_locked"}, 32'(locked),  32'(g.locked));
        if (want >= 0) check({g.tag, "_want"}, 32'(gnt_idx), want);
        xf = g.vld && rdy;
        for (int j = 0; j < N; j++) begin
            if (xf && (g.idx == j)) m_age[j] = 0;
            else if (vld[j] && !m_locked && (m_age[j] < AGE_TH)) m_age[j]++;
        end
        if (xf) begin
            if (tail[g.idx]) begin
                m_locked = 1'b0;
                m_rr     = (g.idx + 1) % N;
            end else begin
                m_locked = 1'b1;
                m_lock   = g.idx;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        rst  = 1'b1;
        vld  = '1;
        pri  = '0;
        tail = '1;
        rdy  = 1'b1;
        v1   = 1'b0;
        t1   = 1'b1;
        r1   = 1'b1;
        p1   = '0;
        #1;
        check("rst_vld",    32'(gnt_vld), 0);
        check("rst_oh",     32'(gnt_oh),  0);
        check("rst_idx",    32'(gnt_idx), 0);
        check("rst_locked", 32'(locked),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Equal priorities rotate from pointer 0.
        pri = {4'd5, 4'd5, 4'd5, 4'd5};
        for (int c = 0; c < 8; c++) step("rr_equal", c % N);

        // Strict priority: requester 1 (pri 9) always wins.
        pri = {4'd8, 4'd2, 4'd9, 4'd3};
        for (int c = 0; c < 3; c++) step("prio", 1);

        // Packet lock on requester 2, then a higher-priority request arrives.
        pri  = {4'd1, 4'd4, 4'd1, 4'd9};
        vld  = 4'b0100;
        tail = 4'b0000;
        for (int c = 0; c < 3; c++) step("lock_body", 2);
        vld = 4'b0101;
        step("lock_hold", 2);
        tail = 4'b0100;
        step("lock_tail", 2);
        tail = 4'b1111;
        step("after_lock", 0);

        // Back-pressure holds state; transfer on first ready cycle.
        vld = 4'b1111;
        pri = {4'd5, 4'd5, 4'd5, 4'd5};
        rdy = 1'b0;
        for (int c = 0; c < 5; c++) step("stall", 1);
        rdy = 1'b1;
        step("stall_go", 1);
        step("stall_next", 2);

        // Locked requester drops its valid: no grant, still locked.
        vld  = 4'b1000;
        tail = 4'b0000;
        step("lock3", 3);
        vld = 4'b0111;
        step("lock3_drop", 0);
        vld = 4'b1111;
        step("lock3_back", 3);

        // Reset mid-packet: outputs clear at once, then IDLE with pointer 0.
        rst = 1'b1;
        #1;
        check("midrst_vld",    32'(gnt_vld), 0);
        check("midrst_oh",     32'(gnt_oh),  0);
        check("midrst_idx",    32'(gnt_idx), 0);
        check("midrst_locked", 32'(locked),  0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        tail = 4'b1111;
        step("post_rst", 0);

        // Random traffic against the model.
        for (int c = 0; c < 300; c++) begin
            vld  = N'($urandom_range(0, 15));
            tail = N'($urandom_range(0, 15));
            rdy  = ($urandom_range(0, 3) != 0);
            for (int j = 0; j < N; j++) pri[j] = 4'($urandom_range(0, 3));
            step("rand", -1);
        end

`ifdef PRIORITY_RR_ARB_AGING_EN
        // Low-priority requester 0 is served once its age reaches the threshold.
        vld  = 4'b0000;
        tail = 4'b1111;
        rdy  = 1'b1;
        do_reset();
        pri = {4'd0, 4'd0, 4'd9, 4'd1};
        vld = 4'b0011;
        for (int c = 1; c <= 20; c++) step("aging", (c == 16) ? 0 : 1);
`endif

        // Single requester: granted whenever valid.
        for (int c = 0; c < 8; c++) begin
            v1 = 1'($urandom_range(0, 1));
            t1 = c[0];
            #1;
            check("n1_vld", 32'(gnt_vld1), 32'(v1));
            check("n1_idx", 32'(gnt_idx1), 0);
            check("n1_oh",  32'(gnt_oh1),  32'(v1));
            @(posedge clk);
            #1;
        end

        if (sb.size() != 0) check("sb_empty", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/priority_rr_arbiter.md
PRIORITY_RR_ARBITER -- requirements
Module: priority_rr_arbiter

Interface
REQ-001 SHALL have parameter INPUT_NUM, default 4, number of requesters.
REQ-002 SHALL have parameter INPUT_NUM_IDX_W, default (INPUT_NUM>1 ? clog2(INPUT_NUM) : 1), grant index width.
REQ-003 SHALL have parameter INPUT_PRIORITY_W, default 4, priority field width.
REQ-004 SHALL have parameter AGE_THRESHOLD, default 15, starvation limit in cycles (used only with aging).
REQ-005 SHALL have port clk, input, 1, single clock; all state on rising edge.
REQ-006 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 SHALL have port req_vld_i, input, INPUT_NUM, per-requester valid.
REQ-008 SHALL have port req_priority_i, input, INPUT_NUM x INPUT_PRIORITY_W, per-requester priority; larger means higher.
REQ-009 SHALL have port req_tail_i, input, INPUT_NUM, marks the last flit of a packet.
REQ-010 SHALL have port gnt_rdy_i, input, 1, downstream ready.
REQ-011 SHALL have port gnt_vld_o, output, 1, a grant is presented.
REQ-012 SHALL have port gnt_oh_o, output, INPUT_NUM, one-hot grant; all zero when gnt_vld_o=0.
REQ-013 SHALL have port gnt_idx_o, output, INPUT_NUM_IDX_W, binary index of the grant; 0 when gnt_vld_o=0.
REQ-014 SHALL have port locked_o, output, 1, arbiter is in LOCKED state.

Function
REQ-015 SHALL be zero-latency: gnt_* are combinational from the inputs and the current state.
REQ-016 SHALL define a transfer as gnt_vld_o & gnt_rdy_i in a cycle; state updates only on transfers.
REQ-017 SHALL use FSM states IDLE and LOCKED(lock_idx).
REQ-018 In IDLE: candidate set = valid requesters whose priority is >= every other valid requester's priority (highest-priority set; ties included).
REQ-019 In IDLE: grant = first candidate at or after rr_ptr, wrapping modulo INPUT_NUM; gnt_vld_o = |req_vld_i.
REQ-020 In IDLE: a transfer with req_tail_i[grant]=0 SHALL move to LOCKED with lock_idx=grant.
REQ-021 In IDLE: a transfer with req_tail_i[grant]=1 SHALL stay IDLE (single-flit packet).
REQ-022 In LOCKED: grant is only lock_idx; gnt_vld_o = req_vld_i[lock_idx]; higher-priority requesters are ignored.
REQ-023 In LOCKED: a transfer with req_tail_i[lock_idx]=1 SHALL return to IDLE; otherwise stay LOCKED.
REQ-024 In LOCKED: if req_vld_i[lock_idx] drops, stay LOCKED with gnt_vld_o=0.
REQ-025 rr_ptr SHALL update to (grant+1) mod INPUT_NUM on every tail transfer, in either state; it SHALL NOT change otherwise.
REQ-026 gnt_rdy_i=0 SHALL hold all state; the grant may change in IDLE if the inputs change.
REQ-027 INPUT_NUM=1: requester 0 granted whenever valid; rr_ptr stays 0.

Reset
REQ-028 rst SHALL asynchronously force: state IDLE, rr_ptr 0, lock_idx 0, age counters 0.
REQ-029 Under reset: gnt_vld_o=0, gnt_oh_o=0, gnt_idx_o=0, locked_o=0.
REQ-030 Reset mid-packet SHALL abandon the lock; no recovery is performed.

Configuration
REQ-031 Macro PRIORITY_RR_ARB_AGING_EN SHALL gate the aging logic.
REQ-032 With the macro defined: each requester has a saturating age counter.
- Increments each cycle the requester is valid, in IDLE, and not transferred.
- Clears on a transfer from that requester.
REQ-033 With the macro defined: a requester with age >= AGE_THRESHOLD is "aged".
- If any requester is aged, the candidate set = the aged requesters, regardless of priority.
- Round-robin from rr_ptr applies among them.
REQ-034 Without the macro: no age counters exist, and behaviour is exactly REQ-018..REQ-027.

Verification
REQ-035 Priorities {3,9,2,8}, all valid, rdy=1, tail=1 -> grant idx 1 every cycle; rr_ptr=2 after each transfer.
REQ-036 Priorities {5,5,5,5}, all valid, tail=1, rdy=1 for 8 cycles -> grant order 0,1,2,3,0,1,2,3.
REQ-037 Req 2 wins with tail=0 for 3 flits, then a higher-priority req 0 arrives -> locked_o=1, grants stay on 2 until the tail transfer, then 0 is granted.
REQ-038 Grant presented with rdy=0 for 5 cycles -> state and rr_ptr unchanged; the transfer occurs on the first rdy=1 cycle.
REQ-039 rst asserted mid-packet (LOCKED on idx 3) -> outputs 0 immediately; after release, IDLE with rr_ptr=0.
REQ-040 With PRIORITY_RR_ARB_AGING_EN and AGE_THRESHOLD=15: req0 pri 1, req1 pri 9, both always valid, tail=1 -> req0 granted on cycle 16 (first cycle its age reaches 15), then req1 resumes.
